// File: rtl/reg_file_arbiter_pkg.sv
// Shared constants and types for the A/B/C register-file arbiter.
package reg_file_arbiter_pkg;

  // Datapath constants
  localparam int WORD_SIZE = 19;
  localparam int SEL_W     = 2;

  // LOAD_SELECT encodings
  localparam logic [SEL_W-1:0] LOAD_REG_A    = 2'b00;
  localparam logic [SEL_W-1:0] LOAD_REG_B    = 2'b01;
  localparam logic [SEL_W-1:0] LOAD_REG_C    = 2'b10;
  localparam logic [SEL_W-1:0] LOAD_REG_NONE = 2'b11;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2,
    RESP    = 2'd3
  } reg_arb_state_t;

  // One granted access, frozen at grant time
  typedef struct packed {
    logic                 we;
    logic [SEL_W-1:0]     sel;
    logic [WORD_SIZE-1:0] wdata;
  } reg_req_t;

endpackage

// File: rtl/reg_file_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first set bit of req at or after ptr,
// wrapping modulo NUM_REQ. Generic, also used for bus arbitration.
module rr_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);

  // one extra bit so ptr + offset never overflows before the wrap
  logic [IDX_W:0] pos;

  // scan offsets 0..NUM_REQ-1 from ptr, keep the first hit
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    pos   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      pos = {1'b0, ptr} + (IDX_W+1)'(i);
      if (pos >= (IDX_W+1)'(NUM_REQ)) pos = pos - (IDX_W+1)'(NUM_REQ);
      if (!any && req[pos[IDX_W-1:0]]) begin
        any                   = 1'b1;
        grant[pos[IDX_W-1:0]] = 1'b1;
        idx                   = pos[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/reg_file_arbiter.sv
// Round-robin arbiter sharing the A/B/C register file between requesters.
// Each grant becomes a one-cycle LOAD_REG/LOAD_SELECT command; exactly one
// access is in flight, so responses come back in grant order.
module reg_file_arbiter #(
  parameter int NUM_REQ   = 3,
  parameter int WORD_SIZE = reg_file_arbiter_pkg::WORD_SIZE,
  parameter int SEL_W     = reg_file_arbiter_pkg::SEL_W
) (
  input  logic                               CLK,
  input  logic                               RST,
  input  logic [NUM_REQ-1:0]                 req_valid,
  output logic [NUM_REQ-1:0]                 req_ready,
  input  logic [NUM_REQ-1:0]                 req_we,
  input  logic [NUM_REQ-1:0][SEL_W-1:0]      req_sel,
  input  logic [NUM_REQ-1:0][WORD_SIZE-1:0]  req_wdata,
  output logic [NUM_REQ-1:0]                 rsp_valid,
  output logic                               rsp_err,
  output logic [WORD_SIZE-1:0]               rsp_rdata,
  output logic                               reg_load,
  output logic [SEL_W-1:0]                   reg_select,
  output logic [WORD_SIZE-1:0]               reg_wdata,
  input  logic [WORD_SIZE-1:0]               reg_rdata
);
  import reg_file_arbiter_pkg::*;

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  reg_arb_state_t       state, nstate;
  logic [IDX_W-1:0]     rr_ptr;
  logic [NUM_REQ-1:0]   own;      // one-hot owner of the access in flight
  reg_req_t             lat;
  logic                 is_err;

  logic [NUM_REQ-1:0]   grant;
  logic [IDX_W-1:0]     gidx;
  logic                 gany;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_rr (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .grant (grant),
    .idx   (gidx),
    .any   (gany)
  );

  assign is_err = (lat.sel == LOAD_REG_NONE);

  // state register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= nstate;
  end

  // next-state: writes and bad selects skip CAPTURE
  always_comb begin
    nstate = state;
    case (state)
      IDLE:    if (gany) nstate = ISSUE;
      ISSUE:   nstate = (lat.we || is_err) ? RESP : CAPTURE;
      CAPTURE: nstate = RESP;
      RESP:    nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  // freeze the granted request and advance the round-robin pointer
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rr_ptr <= '0;
      own    <= '0;
      lat    <= '{we: 1'b0, sel: LOAD_REG_NONE, wdata: '0};
    end else if (state == IDLE && gany) begin
      rr_ptr <= (gidx == IDX_W'(NUM_REQ-1)) ? '0 : gidx + 1'b1;
      own    <= grant;
      lat    <= '{we: req_we[gidx], sel: req_sel[gidx], wdata: req_wdata[gidx]};
    end
  end

  // read data arrives from the register file during CAPTURE and is held
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)                    rsp_rdata <= '0;
    else if (state == CAPTURE)  rsp_rdata <= reg_rdata;
  end

  // outputs: only ISSUE drives a real select; req_ready masked while in reset
  always_comb begin
    req_ready  = '0;
    rsp_valid  = '0;
    rsp_err    = 1'b0;
    reg_load   = 1'b0;
    reg_select = LOAD_REG_NONE;
    reg_wdata  = '0;
    case (state)
      IDLE:  if (!RST) req_ready = grant;
      ISSUE: begin
        reg_load   = lat.we && !is_err;
        reg_select = lat.sel;
        reg_wdata  = lat.wdata;
      end
      RESP: begin
        rsp_valid = own;
        rsp_err   = is_err;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_reg_file_arbiter.sv
// Scoreboard bench for reg_file_arbiter with a behavioural A/B/C register file.
module tb_reg_file_arbiter;
  localparam int N = 3;
  localparam int W = 19;

  logic                 CLK = 1'b0;
  logic                 RST;
  logic [N-1:0]         req_valid, req_ready, req_we, rsp_valid;
  logic [N-1:0][1:0]    req_sel;
  logic [N-1:0][W-1:0]  req_wdata;
  logic                 rsp_err, reg_load;
  logic [W-1:0]         rsp_rdata, reg_wdata;
  logic [W-1:0]         reg_rdata = '0;
  logic [1:0]           reg_select;

  reg_file_arbiter #(.NUM_REQ(N), .WORD_SIZE(W), .SEL_W(2)) dut (
    .CLK(CLK), .RST(RST),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_sel(req_sel), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
    .reg_load(reg_load), .reg_select(reg_select), .reg_wdata(reg_wdata),
    .reg_rdata(reg_rdata)
  );

  always #5 CLK = ~CLK;

  // register file: write on load, else register the selected entry
  logic [W-1:0] rf [4] = '{default: '0};
  always @(posedge CLK) begin
    if (reg_select != 2'b11) begin
      if (reg_load) rf[reg_select] <= reg_wdata;
      else          reg_rdata      <= rf[reg_select];
    end
  end

  typedef struct {
    int         idx;
    bit         we;
    bit         err;
    logic [1:0] sel;
    logic [W-1:0] wdata;
    logic [W-1:0] rdata;
    int         t;
  } exp_t;

  exp_t         sb[$];
  logic [W-1:0] shadow [4] = '{default: '0};
  logic [W-1:0] last_rd = '0;
  int total = 0, bad = 0, cyc = 0, tb_ptr = 0, gcount = 0, last_wait = 0, g0 = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h (cyc %0d)", tag, act, exp, cyc);
    end
  endtask

  initial forever begin
    @(posedge CLK);
    cyc++;
  end

  // monitor: grant order model, issue command, responses
  initial forever begin
    int   g;
    exp_t e;
    @(negedge CLK);
    if (!RST) begin
      if (req_ready != '0) begin
        g = -1;
        for (int k = 0; k < N; k++)
          if (g < 0 && req_valid[(tb_ptr + k) % N]) g = (tb_ptr + k) % N;
        chk("grant_busy", sb.size(), 0);
        chk("grant_oh", req_ready, (g < 0) ? 32'd0 : (32'd1 << g));
        if (g >= 0) begin
          e.idx = g; e.we = req_we[g]; e.sel = req_sel[g]; e.wdata = req_wdata[g];
          e.err = (e.sel == 2'b11); e.t = cyc; e.rdata = '0;
          if (!e.err && e.we)  shadow[e.sel] = e.wdata;
          if (!e.err && !e.we) e.rdata = shadow[e.sel];
          sb.push_back(e);
          tb_ptr = (g + 1) % N;
          gcount++;
        end
      end
      if (sb.size() > 0 && cyc == sb[0].t + 1) begin
        chk("iss_load", reg_load, sb[0].we && !sb[0].err);
        chk("iss_sel", reg_select, sb[0].sel);
        if (sb[0].we && !sb[0].err) chk("iss_wdata", reg_wdata, sb[0].wdata);
      end else begin
        chk("hold_sel", reg_select, 2'b11);
        chk("hold_load", reg_load, 0);
      end
      if (rsp_valid != '0) begin
        if (sb.size() == 0) chk("spurious_rsp", rsp_valid, 0);
        else begin
          e = sb.pop_front();
          chk("rsp_oh", rsp_valid, 32'd1 << e.idx);
          chk("rsp_lat", cyc - e.t, (e.we || e.err) ? 2 : 3);
          chk("rsp_err", rsp_err, e.err);
          if (!e.we && !e.err) last_rd = e.rdata;
          chk("rsp_rdata", rsp_rdata, last_rd);
        end
      end else if (sb.size() > 0 && cyc > sb[0].t + 3) begin
        chk("rsp_timeout", 0, 1);
        void'(sb.pop_front());
      end
    end
  end

  // raise a request, hold it until granted, then scramble the fields
  task automatic req_once(input int r, input bit we, input logic [1:0] sel, input logic [W-1:0] wd);
    bit got = 1'b0;
    req_we[r] = we; req_sel[r] = sel; req_wdata[r] = wd; req_valid[r] = 1'b1;
    for (int n = 1; n <= 60 && !got; n++) begin
      @(negedge CLK);
      if (req_ready[r]) begin got = 1'b1; last_wait = n; end
    end
    if (!got) chk("grant_timeout", 0, 1);
    else @(posedge CLK);
    #1;
    req_valid[r] = 1'b0; req_wdata[r] = ~wd; req_sel[r] = ~sel; req_we[r] = ~we;
  endtask

  task automatic drain();
    for (int n = 0; n < 20 && sb.size() != 0; n++) @(negedge CLK);
    @(posedge CLK); #1;
  endtask

  initial begin
    RST = 1'b1; req_valid = '0; req_we = '0; req_sel = '0; req_wdata = '0;
    repeat (2) @(posedge CLK); #1;
    req_valid = '1; #1;
    chk("rst_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_rdata", rsp_rdata, 0);
    chk("rst_load", reg_load, 0);
    chk("rst_sel", reg_select, 2'b11);
    chk("rst_wdata", reg_wdata, 0);
    req_valid = '0;
    @(posedge CLK); #1; RST = 1'b0;
    repeat (2) @(posedge CLK); #1;

    // single write then read-back by another requester
    req_once(0, 1'b1, 2'b00, 19'h1ABCD); drain();
    req_once(1, 1'b0, 2'b00, 19'h0);     drain();
    req_once(2, 1'b0, 2'b00, 19'h0);     drain();   // pointer back to 0

    // three simultaneous writes to B: grants 0,1,2; then reads see 3
    fork
      req_once(0, 1'b1, 2'b01, 19'd1);
      req_once(1, 1'b1, 2'b01, 19'd2);
      req_once(2, 1'b1, 2'b01, 19'd3);
    join
    drain();
    fork
      req_once(1, 1'b0, 2'b01, 19'h0);
      req_once(0, 1'b0, 2'b01, 19'h0);
    join
    drain();

    // fairness: requester 0 streams while requester 2 asks once
    fork
      begin
        for (int i = 0; i < 4; i++) req_once(0, 1'b1, 2'b00, 19'(16 + i));
      end
      begin
        repeat (3) @(posedge CLK); #1;
        g0 = gcount;
        req_once(2, 1'b0, 2'b00, 19'h0);
        chk("fair_r2", (gcount - g0) <= 2, 1);
      end
    join
    drain();

    // bad select: read and write with sel=11
    req_once(1, 1'b0, 2'b11, 19'h0);     drain();
    req_once(0, 1'b1, 2'b11, 19'h55555); drain();

    // full-width value
    req_once(2, 1'b1, 2'b10, 19'h7FFFF); drain();
    req_once(0, 1'b0, 2'b10, 19'h0);     drain();

    // reset during CAPTURE of a read
    req_once(1, 1'b0, 2'b01, 19'h0);     // returns inside ISSUE
    @(posedge CLK); #2;
    RST = 1'b1; #1;
    chk("mid_rsp_valid", rsp_valid, 0);
    chk("mid_sel", reg_select, 2'b11);
    chk("mid_load", reg_load, 0);
    chk("mid_rdata", rsp_rdata, 0);
    chk("mid_err", rsp_err, 0);
    sb.delete(); tb_ptr = 0; last_rd = '0;
    repeat (3) @(posedge CLK); #1;
    RST = 1'b0;
    repeat (5) @(posedge CLK); #1;
    req_once(1, 1'b1, 2'b10, 19'h12345);
    chk("idle_after_rst", last_wait, 1);
    drain();
    req_once(0, 1'b0, 2'b10, 19'h0);     drain();

    // short random mix across requesters
    for (int it = 0; it < 8; it++) begin
      fork
        begin if ($urandom_range(1)) req_once(0, 1'($urandom_range(1)), 2'($urandom_range(3)), 19'($urandom)); end
        begin if ($urandom_range(1)) req_once(1, 1'($urandom_range(1)), 2'($urandom_range(3)), 19'($urandom)); end
        begin req_once(2, 1'($urandom_range(1)), 2'($urandom_range(3)), 19'($urandom)); end
      join
      drain();
    end

    drain();
    chk("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/reg_file_arbiter.md
Name: reg_file_arbiter

Overview:
- Shares the three-entry A/B/C register file between up to NUM_REQ requesters, e.g. decode/operand fetch, ALU writeback and the debug port.
- Arbitrates round-robin and serialises each granted access into a single-cycle LOAD_REG/LOAD_SELECT command.
- Returns write acknowledges and read data per requester.
- Sits between the control unit and the register file's control_bus_if/data_bus_if.

Parameters:
- NUM_REQ, 3, number of requesters (2..4).
- WORD_SIZE, 19, datapath width (taken from constants package).
- SEL_W, 2, register-select width.

Ports:
- CLK  input  1  system clock, rising edge.
- RST  input  1  asynchronous, active-high reset.
- req_valid  input  NUM_REQ  per-requester request valid; held until granted.
- req_ready  output  NUM_REQ  one-hot grant pulse; request accepted this cycle.
- req_we  input  NUM_REQ  1 = write, 0 = read, per requester.
- req_sel  input  NUM_REQ x SEL_W  target register: 00=A, 01=B, 10=C, 11=none.
- req_wdata  input  NUM_REQ x WORD_SIZE  write data.
- rsp_valid  output  NUM_REQ  one-hot, one-cycle completion pulse to the owning requester.
- rsp_err  output  1  qualifies rsp_valid; 1 = request had sel=11.
- rsp_rdata  output  WORD_SIZE  read data; valid only with rsp_valid for a read.
- reg_load  output  1  to LOAD_REG.
- reg_select  output  SEL_W  to LOAD_SELECT.
- reg_wdata  output  WORD_SIZE  to data_in.
- reg_rdata  input  WORD_SIZE  from data_out, which the register file registers one cycle after a read command.

Behaviour:
- Reset (async assert, sync release):
  - FSM=IDLE, rr_ptr=0, all req_ready/rsp_valid=0, rsp_err=0.
  - rsp_rdata=0, reg_load=0, reg_select=11, reg_wdata=0.
- Outside ISSUE: reg_load=0 and reg_select=11, so the register file holds. Only ISSUE drives a real select.
- FSM states: IDLE, ISSUE, CAPTURE, RESP.
- IDLE:
  - If any req_valid, grant the first valid index at or after rr_ptr, wrapping modulo NUM_REQ.
  - Pulse req_ready[g] and latch g, we, sel and wdata.
  - Set rr_ptr=(g+1) mod NUM_REQ. Next state ISSUE.
  - If none valid, stay in IDLE.
- ISSUE (one cycle):
  - Drive reg_load=we, reg_select=sel, reg_wdata=wdata.
  - Write -> RESP. Read -> CAPTURE.
  - sel=11: drive reg_select=11 (no-op), set err, go to RESP.
- CAPTURE: reg_rdata is valid this cycle; register it into rsp_rdata. Next state RESP.
- RESP: pulse rsp_valid[g] with rsp_err=err. Next state IDLE.
- Latency, with grant at cycle T:
  - Write: register updated at the T+1 edge; rsp_valid at T+2.
  - Read: rsp_valid with rsp_rdata at T+3.
  - Error: rsp_valid with rsp_err=1 at T+2.
- Throughput: next grant occurs no earlier than the cycle after RESP. One access is outstanding at a time.
- rsp_rdata holds its last read value between reads; writes do not disturb it.
- Ordering: accesses complete in grant order. A read granted after a write to the same register returns the new value.
- Request fields are sampled only in the grant cycle; later changes are ignored.
- A requester re-asserting in the cycle after its own grant is still subject to round-robin order.
- Reset mid-operation: outstanding access is dropped, no rsp_valid is produced. Any write already issued in ISSUE stays committed in the register file.
- req_valid deasserted before grant: that request is simply not granted; no error.

Decomposition:
- constants package: WORD_SIZE.
- opcodes package:
  - LOAD_REG_A/B/C/NONE select encodings (00/01/10/11).
  - reg_arb_state_t enum {IDLE, ISSUE, CAPTURE, RESP}.
  - reg_req_t struct {we, sel, wdata}.
- Sub-module rr_arbiter: parameterised NUM_REQ round-robin priority picker, combinational, taking req vector and pointer, returning one-hot grant plus index. It is reused elsewhere for bus arbitration.

Test Plan:
- Reset then a single write: requester 0 writes A=19'h1ABCD -> req_ready[0] at T, reg_load=1/reg_select=00 at T+1, rsp_valid[0] at T+2. A subsequent read of A by requester 1 returns 19'h1ABCD at its T+3.
- All three requesters assert together at rr_ptr=0, writing B=1, B=2, B=3 -> grants in order 0,1,2. A final read of B returns 3, and rr_ptr ends at 0.
- Fairness: requester 0 asserts continuously while requester 2 asserts once -> requester 2 is granted within two grants, never starved.
- Invalid select: requester 1 reads with sel=11 -> reg_select stays 11 for all cycles, rsp_valid[1] with rsp_err=1 at T+2, and rsp_rdata is unchanged.
- Reset mid-read: assert RST during CAPTURE -> outputs return to reset values immediately, no rsp_valid, and the FSM is in IDLE after release.
- Write C=19'h7FFFF (all ones, max value) then read C -> rsp_rdata=19'h7FFFF, confirming full-width datapath with no truncation.
